// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive-side buffer.
//   - Default FIFO geometry (depth as log2, data width).
//   - Ingress handshake state encoding.
//   - CPU port numbers: 32..34 are the existing UART data/ready/read ports,
//     35 and 36 expose the receive byte count and the sticky overrun flag.
package uart_pkg;

  localparam int UART_DEPTH_LOG2 = 4;
  localparam int UART_WIDTH      = 8;

  localparam logic [7:0] UART_PORT_DATA    = 8'd32;
  localparam logic [7:0] UART_PORT_READY   = 8'd33;
  localparam logic [7:0] UART_PORT_READ    = 8'd34;
  localparam logic [7:0] UART_PORT_COUNT   = 8'd35;
  localparam logic [7:0] UART_PORT_OVERRUN = 8'd36;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: storage array for the receive FIFO.
// Ports:
//   clk, reset   - clock, synchronous active-low reset (read register only)
//   wr_en        - write wr_data into entry wr_addr at the clock edge
//   wr_addr      - write address
//   wr_data      - write data
//   rd_en        - load rd_data from entry rd_addr at the clock edge
//   rd_addr      - read address
//   rd_data      - registered read data (cleared by reset)
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2,
  parameter int WIDTH      = UART_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // RAM array write port; contents are not reset (pointers define validity).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; a write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// housekeeping CPU read ports.
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-low reset
//   rx_data      - byte from the receiver, valid while rx_ready=1
//   rx_ready     - receiver holds a byte
//   rx_read      - 4-phase acknowledge back to the receiver
//   cpu_data     - registered FIFO head byte
//   cpu_ready    - registered "FIFO not empty"
//   cpu_read     - CPU read request (level); a 0->1 edge pops one byte
//   count        - number of bytes queued, 0..2^DEPTH_LOG2
//   overrun      - sticky: a byte was dropped because the FIFO was full
//   overrun_clr  - one-cycle clear of overrun (a coincident drop wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2,
  parameter int WIDTH      = UART_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      rx_data,
  input  logic                  rx_ready,
  output logic                  rx_read,
  output logic [WIDTH-1:0]      cpu_data,
  output logic                  cpu_ready,
  input  logic                  cpu_read,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  rx_state_e             state_r, state_s;
  logic                  rx_read_r, rx_read_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_s;
  logic                  cpu_ready_r;
  logic                  overrun_r, overrun_s;
  logic                  cpu_read_d_r;

  logic                  rise_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  full_eff_s;
  logic [CNT_W-1:0]      count_after_pop_s;
  logic                  rd_en_s;

  // Pop qualification; fullness is judged after any pop in the same cycle so a
  // simultaneous pop makes room for the incoming byte.
  always_comb begin
    rise_s            = cpu_read & ~cpu_read_d_r;
    pop_s             = 1'b0;
    if (rise_s && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    count_after_pop_s = count_r - {{DEPTH_LOG2{1'b0}}, pop_s};
    full_eff_s        = (count_after_pop_s == CNT_FULL);
    rd_en_s           = (count_r != CNT_ZERO);
  end

  // Ingress handshake next-state: one write or drop per rx_ready assertion.
  always_comb begin
    state_s   = state_r;
    rx_read_s = rx_read_r;
    push_s    = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (rx_ready) begin
          state_s   = RX_ACK;
          rx_read_s = 1'b1;
          if (full_eff_s) begin
            drop_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          state_s   = RX_IDLE;
          rx_read_s = 1'b0;
        end
      end
      RX_ACK: begin
        if (!rx_ready) begin
          state_s   = RX_IDLE;
          rx_read_s = 1'b0;
        end else begin
          state_s   = RX_ACK;
          rx_read_s = 1'b1;
        end
      end
      default: begin
        state_s   = RX_IDLE;
        rx_read_s = 1'b0;
      end
    endcase
  end

  // Occupancy and sticky-overrun next values.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
    overrun_s = overrun_r;
    if (drop_s) begin
      overrun_s = 1'b1;
    end else if (overrun_clr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State, pointer, counter and flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= RX_IDLE;
      rx_read_r    <= 1'b0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= CNT_ZERO;
      cpu_ready_r  <= 1'b0;
      overrun_r    <= 1'b0;
      // Start high so a cpu_read held across reset release is not an edge.
      cpu_read_d_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      rx_read_r    <= rx_read_s;
      count_r      <= count_s;
      cpu_ready_r  <= (count_r != CNT_ZERO);
      overrun_r    <= overrun_s;
      cpu_read_d_r <= cpu_read;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (rx_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r),
    .rd_data (cpu_data)
  );

  assign rx_read   = rx_read_r;
  assign cpu_ready = cpu_ready_r;
  assign count     = count_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_read;
  logic [7:0] cpu_data;
  logic       cpu_ready;
  logic       cpu_read;
  logic [4:0] count;
  logic       overrun;
  logic       overrun_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_read     (rx_read),
    .cpu_data    (cpu_data),
    .cpu_ready   (cpu_ready),
    .cpu_read    (cpu_read),
    .count       (count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_byte(output logic [7:0] b);
    b        = cpu_data;
    cpu_read = 1'b1;
    tick();
    cpu_read = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; cpu_read = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    n_cmp++; if (rx_read !== 1'b0) begin n_err++; $display("FAIL reset_rx_read: got %b want 0", rx_read); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (cpu_data !== 8'h00) begin n_err++; $display("FAIL reset_cpu_data: got %h want 00", cpu_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    rx_data = 8'hA5; rx_ready = 1'b1;
    tick();  // edge N
    n_cmp++; if (rx_read !== 1'b1) begin n_err++; $display("FAIL single_ack_rise: got %b want 1", rx_read); end
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    tick();  // edge N+1
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL single_cpu_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_data !== 8'hA5) begin n_err++; $display("FAIL single_cpu_data: got %h want a5", cpu_data); end
    tick();  // edge N+2, rx_ready still high
    n_cmp++; if (rx_read !== 1'b1) begin n_err++; $display("FAIL single_ack_hold: got %b want 1", rx_read); end
    rx_ready = 1'b0;
    tick();
    n_cmp++; if (rx_read !== 1'b0) begin n_err++; $display("FAIL single_ack_fall: got %b want 0", rx_read); end
    cpu_read = 1'b1;
    tick();
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", count); end
    tick();
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL single_pop_ready: got %b want 0", cpu_ready); end
    cpu_read = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL burst_count: got %0d want 16", count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL burst_overrun: got %b want 0", overrun); end
    // First read held high for five cycles must pop exactly once.
    d = cpu_data;
    cpu_read = 1'b1;
    repeat (5) tick();
    cpu_read = 1'b0;
    tick();
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL burst_data_0: got %h want 00", d); end
    n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL burst_held_read: got %0d want 15", count); end
    for (int i = 1; i < 16; i++) begin
      pop_byte(d);
      n_cmp++; if (d !== 8'(i)) begin n_err++; $display("FAIL burst_data_%0d: got %h want %h", i, d, 8'(i)); end
    end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL burst_drained: got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    rx_data = 8'h10; rx_ready = 1'b1;
    tick();
    n_cmp++; if (rx_read !== 1'b1) begin n_err++; $display("FAIL ovf_ack: got %b want 1", rx_read); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overrun); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", count); end
    rx_ready = 1'b0;
    tick();
    n_cmp++; if (rx_read !== 1'b0) begin n_err++; $display("FAIL ovf_ack_fall: got %b want 0", rx_read); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overrun); end
    // Drop and clear on the same edge: the set must win.
    rx_data = 8'h11; rx_ready = 1'b1; overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0; rx_ready = 1'b0;
    tick();
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overrun); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count2: got %0d want 16", count); end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  task automatic test_wrap_simultaneous();
    logic [7:0] d;
    logic [7:0] exp_q [16];
    // FIFO holds 00..0F with both pointers at 0; rotate by three to force a wrap.
    for (int i = 0; i < 3; i++) begin
      pop_byte(d);
      n_cmp++; if (d !== 8'(i)) begin n_err++; $display("FAIL wrap_pre_pop_%0d: got %h want %h", i, d, 8'(i)); end
    end
    push_byte(8'h20); push_byte(8'h21); push_byte(8'h22);
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL wrap_refill: got %0d want 16", count); end
    n_cmp++; if (cpu_data !== 8'h03) begin n_err++; $display("FAIL wrap_head: got %h want 03", cpu_data); end
    rx_data = 8'h55; rx_ready = 1'b1; cpu_read = 1'b1;
    tick();
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL wrap_simul_count: got %0d want 16", count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL wrap_simul_overrun: got %b want 0", overrun); end
    rx_ready = 1'b0; cpu_read = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) exp_q[i] = 8'(i + 4);
    exp_q[12] = 8'h20; exp_q[13] = 8'h21; exp_q[14] = 8'h22; exp_q[15] = 8'h55;
    for (int i = 0; i < 16; i++) begin
      pop_byte(d);
      n_cmp++; if (d !== exp_q[i]) begin n_err++; $display("FAIL wrap_drain_%0d: got %h want %h", i, d, exp_q[i]); end
    end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL wrap_drained: got %0d want 0", count); end
  endtask

  task automatic test_empty_read();
    logic [7:0] d;
    repeat (3) begin
      cpu_read = 1'b1; tick();
      cpu_read = 1'b0; tick();
    end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL empty_count: got %0d want 0", count); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL empty_ready: got %b want 0", cpu_ready); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL empty_overrun: got %b want 0", overrun); end
    push_byte(8'h3C);
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL empty_then_count: got %0d want 1", count); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL empty_then_ready: got %b want 1", cpu_ready); end
    n_cmp++; if (cpu_data !== 8'h3C) begin n_err++; $display("FAIL empty_then_data: got %h want 3c", cpu_data); end
    pop_byte(d);
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL empty_then_pop: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h40 + i));
    rx_data = 8'h44; rx_ready = 1'b1;
    tick();
    n_cmp++; if (rx_read !== 1'b1) begin n_err++; $display("FAIL rst_pre_ack: got %b want 1", rx_read); end
    n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL rst_pre_count: got %0d want 5", count); end
    reset = 1'b0; cpu_read = 1'b1;
    tick();
    n_cmp++; if (rx_read !== 1'b0) begin n_err++; $display("FAIL rst_rx_read: got %b want 0", rx_read); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_ready); end
    // Receiver still holds a byte and cpu_read stays high across release.
    reset = 1'b1; rx_data = 8'h77;
    tick();
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL rst_retake_count: got %0d want 1", count); end
    tick();
    n_cmp++; if (cpu_data !== 8'h77) begin n_err++; $display("FAIL rst_retake_data: got %h want 77", cpu_data); end
    repeat (3) tick();
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL rst_no_pop: got %0d want 1", count); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cpu_ready); end
    cpu_read = 1'b0; rx_ready = 1'b0;
    tick();
    n_cmp++; if (rx_read !== 1'b0) begin n_err++; $display("FAIL rst_ack_fall: got %b want 0", rx_read); end
    pop_byte(d);
    n_cmp++; if (d !== 8'h77) begin n_err++; $display("FAIL rst_pop_data: got %h want 77", d); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL rst_pop_count: got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_wrap_simultaneous();
    test_empty_read();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART receiver and the housekeeping CPU's UART read ports (data, ready, read).
- Drains each byte from the receiver with a 4-phase ready/read handshake and queues it in a small synchronous FIFO.
- Presents the queue head to the CPU with the same level-style ready/read semantics, so host bursts are not lost while firmware is busy.
- Adds a byte count and a sticky overrun flag, readable as extra input ports.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- rx_data  input  WIDTH  byte from UART receiver, valid while rx_ready=1
- rx_ready  input  1  receiver holds a byte
- rx_read  output  1  acknowledge to receiver (4-phase)
- cpu_data  output  WIDTH  FIFO head byte
- cpu_ready  output  1  FIFO not empty
- cpu_read  input  1  CPU read request, level; pop on rising edge
- count  output  DEPTH_LOG2+1  bytes currently queued, 0..2^DEPTH_LOG2
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- overrun_clr  input  1  one-cycle clear of overrun

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low (reset=0 at a posedge clk clears state).
- Reset values:
  - rx_read=0, cpu_ready=0, count=0, overrun=0, cpu_data=0.
  - Pointers=0, ingress FSM=IDLE.
  - cpu_read edge register=1, so a cpu_read held high across reset release causes no pop.
- Ingress FSM:
  - IDLE:
    - If rx_ready=1 and not full: write rx_data at wr_ptr, wr_ptr+1, rx_read<=1, go to ACK.
    - If rx_ready=1 and full: byte discarded, overrun<=1, rx_read<=1, go to ACK. The receiver is never stalled.
  - ACK: hold rx_read=1 until rx_ready=0, then rx_read<=0 and go to IDLE. Exactly one write per rx_ready assertion.
- Egress:
  - cpu_ready = (count != 0), registered.
  - cpu_data is registered: the head byte, updated the cycle after any push into an empty FIFO or any pop.
  - Pop on a cpu_read 0->1 edge while count != 0: rd_ptr+1.
  - A rising edge while empty is ignored: no pointer change, no error flag.
- Latency: a byte written in IDLE at edge N is visible on cpu_data/cpu_ready after edge N+1.
- Count and pointers:
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is DEPTH_LOG2+1 bits.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted. Full is evaluated as count minus the pending pop.
- Overrun: set on a drop. Cleared by overrun_clr=1. If set and clear coincide, set wins.
- Reset mid-operation: FIFO contents are discarded and rx_read drops immediately. If the receiver still asserts rx_ready after reset, the byte is taken as new in IDLE.

Decomposition:
- Shared package uart_pkg:
  - Ingress state encoding (IDLE, ACK).
  - Default DEPTH_LOG2/WIDTH constants.
  - CPU port-number constants for count (35) and overrun (36) next to the existing 32–34 UART ports.
- One sub-module, uart_rx_fifo_mem: dual-pointer RAM array with write enable, write address, read address and registered read data.
- Handshake FSM, counting, and edge detection stay in the top module.

Test Plan:
- Single byte: rx_data=0xA5, rx_ready pulsed high for 3 cycles then low:
  - rx_read high from the cycle after rx_ready rises until the cycle after rx_ready falls.
  - count=1, cpu_ready=1, cpu_data=0xA5 after edge N+1.
  - cpu_read 0->1 gives count=0, cpu_ready=0.
- Burst fill: 16 bytes 0x00..0x0F:
  - count=16, overrun=0.
  - Then 16 cpu_read edges return 0x00..0x0F in order.
  - cpu_read held high for 5 cycles pops only once.
- Overflow: push 17 bytes with no reads:
  - 17th byte (0x10) dropped, overrun=1, count=16, receiver still acknowledged.
  - overrun_clr clears it; overrun_clr coincident with another drop leaves overrun=1.
- Simultaneous push/pop at count=16 with a pointer wrap:
  - count stays 16.
  - Subsequent drain shows the new byte last and no corruption across the wrap.
- Empty read: cpu_read edges at count=0:
  - No pointer change.
  - A following byte 0x3C reads back correctly with count=1.
- Reset mid-ACK: assert reset=0 while rx_read=1 and count=5:
  - Next cycle rx_read=0, count=0, cpu_ready=0.
  - cpu_read held high through reset release causes no pop.
